// File: rtl/ntcrack_host_if.sv
// Handshake bundle between ntcrack_host, the upstream hash source, the cracker and the password sink.
// master = ntcrack_host side, slave = the surrounding system.
interface ntcrack_host_if;
    logic [7:0] hash_in_byte;
    logic       hash_in_valid;
    logic       hash_in_last;
    logic       hash_in_ready;
    logic [7:0] new_hash_byte;
    logic       store_hash_byte;
    logic       go;
    logic       your_turn;
    logic       match_found;
    logic [7:0] password_byte;
    logic [7:0] pw_out_byte;
    logic       pw_out_valid;
    logic       pw_out_last;
    logic       pw_out_ready;

    modport master (
        input  hash_in_byte, hash_in_valid, hash_in_last,
        output hash_in_ready,
        output new_hash_byte, store_hash_byte, go,
        input  your_turn, match_found, password_byte,
        output pw_out_byte, pw_out_valid, pw_out_last,
        input  pw_out_ready
    );

    modport slave (
        output hash_in_byte, hash_in_valid, hash_in_last,
        input  hash_in_ready,
        input  new_hash_byte, store_hash_byte, go,
        output your_turn, match_found, password_byte,
        input  pw_out_byte, pw_out_valid, pw_out_last,
        output pw_out_ready
    );
endinterface

// File: rtl/ntcrack_host.sv
// Host sequencer: loads a 16-byte hash into the cracker, then streams out 20-byte passwords.
// Optional wait-state timeout is enabled by defining NTCRACK_HOST_TIMEOUT_EN.
module ntcrack_host #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic           clk,
    input  logic           reset,
    ntcrack_host_if.master bus,
    output logic [7:0]     match_count,
    output logic           proto_error
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_STROBE, S_LOAD_WAIT_LOW, S_LOAD_WAIT_HIGH, S_GO_PULSE,
        S_GO_WAIT_LOW, S_CRACK, S_EMIT, S_ACK_PULSE, S_ACK_WAIT_LOW
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_new_hash_byte, r_pw_byte, r_match_count;
    logic       r_last, r_proto_error;
    logic [3:0] r_byte_cnt;
    logic [4:0] r_pw_idx;
    logic       w_accept, w_capture, w_load, w_err, w_pad, w_timeout;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

`ifdef NTCRACK_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_wait;

    always_comb begin
        w_wait    = (r_state == S_LOAD_WAIT_LOW) || (r_state == S_LOAD_WAIT_HIGH) ||
                    (r_state == S_GO_WAIT_LOW)   || (r_state == S_ACK_WAIT_LOW);
        w_timeout = w_wait && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Counter restarts on every state change so each wait gets the full budget.
    always_ff @(posedge clk) begin
        if (reset || !w_wait || (w_next != r_state)) r_to_cnt <= '0;
        else                                          r_to_cnt <= r_to_cnt + TW'(1);
    end
`else
    always_comb w_timeout = 1'b0;
`endif

    always_comb begin
        w_accept  = (r_state == S_IDLE) && bus.your_turn && bus.hash_in_valid;
        w_capture = (r_state == S_CRACK) && bus.match_found && bus.your_turn;
        w_load    = (r_state == S_LOAD_STROBE) || (r_state == S_LOAD_WAIT_LOW) ||
                    (r_state == S_LOAD_WAIT_HIGH);
        w_pad     = (r_state == S_LOAD_WAIT_HIGH) && bus.your_turn && r_last &&
                    (r_byte_cnt != 4'd0);
        w_err     = (bus.match_found && (!bus.your_turn || w_load)) ||
                    (w_accept && bus.hash_in_last && (r_byte_cnt != 4'hF)) || w_timeout;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:           if (w_accept) w_next = S_LOAD_STROBE;
            S_LOAD_STROBE:    w_next = S_LOAD_WAIT_LOW;
            S_LOAD_WAIT_LOW:  if (!bus.your_turn) w_next = S_LOAD_WAIT_HIGH;
            S_LOAD_WAIT_HIGH: begin
                // A short final hash keeps re-entering the strobe with zero bytes until the count wraps.
                if (bus.your_turn) begin
                    if (!r_last)                 w_next = S_IDLE;
                    else if (r_byte_cnt == 4'd0) w_next = S_GO_PULSE;
                    else                         w_next = S_LOAD_STROBE;
                end
            end
            S_GO_PULSE:       w_next = S_GO_WAIT_LOW;
            S_GO_WAIT_LOW:    if (!bus.your_turn) w_next = S_CRACK;
            S_CRACK:          if (w_capture) w_next = S_EMIT;
            S_EMIT:           if (bus.pw_out_ready) w_next = S_ACK_PULSE;
            S_ACK_PULSE:      w_next = S_ACK_WAIT_LOW;
            S_ACK_WAIT_LOW:   if (!bus.your_turn) w_next = S_CRACK;
            default:          w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_new_hash_byte <= '0;
            r_pw_byte       <= '0;
            r_match_count   <= '0;
            r_last          <= 1'b0;
            r_proto_error   <= 1'b0;
            r_byte_cnt      <= '0;
            r_pw_idx        <= '0;
        end else begin
            r_state <= w_next;
            if (w_err) r_proto_error <= 1'b1;
            if (w_accept) begin
                r_new_hash_byte <= bus.hash_in_byte;
                r_last          <= bus.hash_in_last;
            end
            if (w_pad) r_new_hash_byte <= '0;
            if (r_state == S_LOAD_STROBE) r_byte_cnt <= r_byte_cnt + 4'd1;
            if (w_capture) r_pw_byte <= bus.password_byte;
            if ((r_state == S_ACK_WAIT_LOW) && !bus.your_turn && !w_timeout) begin
                if (r_pw_idx == 5'd19) begin
                    r_pw_idx <= '0;
                    if (r_match_count != 8'hFF) r_match_count <= r_match_count + 8'd1;
                end else begin
                    r_pw_idx <= r_pw_idx + 5'd1;
                end
            end
        end
    end

    always_comb begin
        bus.hash_in_ready   = !reset && (r_state == S_IDLE) && bus.your_turn;
        bus.store_hash_byte = !reset && (r_state == S_LOAD_STROBE);
        bus.go              = !reset && ((r_state == S_GO_PULSE) || (r_state == S_ACK_PULSE));
        bus.pw_out_valid    = !reset && (r_state == S_EMIT);
        bus.pw_out_last     = !reset && (r_state == S_EMIT) && (r_pw_idx == 5'd19);
        bus.new_hash_byte   = r_new_hash_byte;
        bus.pw_out_byte     = r_pw_byte;
        match_count         = r_match_count;
        proto_error         = r_proto_error;
    end
endmodule

// File: tb/tb_ntcrack_host.sv
// Bench for ntcrack_host: drives hash bytes, models the cracker, scoreboards stored hash bytes and emitted passwords.
`timescale 1ns/1ps
module tb_ntcrack_host;
`ifdef NTCRACK_HOST_TIMEOUT_EN
    localparam int unsigned TO = 20;
`else
    localparam int unsigned TO = 1023;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] match_count;
    logic       proto_error;

    ntcrack_host_if bus();

    ntcrack_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .match_count (match_count),
        .proto_error (proto_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_store = 0, n_go = 0, n_overlap = 0;
    bit stuck = 1'b0;
    logic [7:0] hash_q[$];
    logic [8:0] pw_q[$];
    logic [7:0] pw [20];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.store_hash_byte) n_store++;
            if (bus.go) n_go++;
            if (bus.store_hash_byte && bus.go) n_overlap++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.your_turn = 1'b1;
        bus.match_found = 1'b0;
        bus.hash_in_valid = 1'b0;
        bus.hash_in_last = 1'b0;
        bus.pw_out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        hash_q.delete();
        pw_q.delete();
        tick();
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit last);
        int n = 0;
        while (!bus.hash_in_ready && n < 200) begin tick(); n++; end
        check_val("ready_wait", 32'(bus.hash_in_ready), 1);
        bus.hash_in_byte = b;
        bus.hash_in_last = last;
        bus.hash_in_valid = 1'b1;
        hash_q.push_back(b);
        tick();
        bus.hash_in_valid = 1'b0;
        bus.hash_in_last = 1'b0;
    endtask

    task automatic serve_load(output bit got_go);
        int n = 0;
        logic [7:0] exp;
        got_go = 1'b0;
        while (!bus.store_hash_byte && !bus.go && n < 200) begin tick(); n++; end
        if (bus.go) begin got_go = 1'b1; return; end
        check_val("store_seen", 32'(bus.store_hash_byte), 1);
        if (!bus.store_hash_byte) return;
        tick();
        check_val("hash_expected", 32'(hash_q.size() != 0), 1);
        exp = (hash_q.size() != 0) ? hash_q.pop_front() : 8'h00;
        check_val("hash_byte", 32'(bus.new_hash_byte), 32'(exp));
        if (stuck) return;
        bus.your_turn = 1'b0;
        tick();
        tick();
        bus.your_turn = 1'b1;
    endtask

    task automatic finish_load(output bit got_go);
        got_go = 1'b0;
        for (int k = 0; k < 20 && !got_go; k++) serve_load(got_go);
        check_val("go_after_load", 32'(got_go), 1);
        tick();
        bus.your_turn = 1'b0;
        tick();
        tick();
    endtask

    task automatic crack_pw(input int stall_idx);
        int n;
        int g1;
        logic [8:0] e;
        for (int i = 0; i < 20; i++) begin
            bus.password_byte = pw[i];
            bus.match_found = 1'b1;
            bus.your_turn = 1'b1;
            pw_q.push_back({(i == 19), pw[i]});
            if (i == stall_idx) bus.pw_out_ready = 1'b0;
            n = 0;
            while (!bus.pw_out_valid && n < 100) begin tick(); n++; end
            check_val("emit_wait", 32'(bus.pw_out_valid), 1);
            if (i == stall_idx) begin
                g1 = n_go;
                repeat (50) tick();
                check_val("stall_valid", 32'(bus.pw_out_valid), 1);
                check_val("stall_byte", 32'(bus.pw_out_byte), 32'(pw[i]));
                check_val("stall_no_go", 32'(n_go - g1), 0);
                bus.pw_out_ready = 1'b1;
            end
            e = pw_q.pop_front();
            check_val("pw_byte", 32'(bus.pw_out_byte), 32'(e[7:0]));
            check_val("pw_last", 32'(bus.pw_out_last), 32'(e[8]));
            tick();
            n = 0;
            while (!bus.go && n < 100) begin tick(); n++; end
            check_val("ack_go", 32'(bus.go), 1);
            bus.your_turn = 1'b0;
            bus.match_found = 1'b0;
            tick();
            tick();
        end
    endtask

    initial begin
        bit   g;
        int   n;
        int   go0, st0;
        string s;

        s = "password";
        for (int i = 0; i < 20; i++) pw[i] = (i < s.len()) ? s[i] : 8'h20;

        // Reset state, with upstream trying to push a byte during reset.
        reset = 1'b1;
        bus.your_turn = 1'b1;
        bus.match_found = 1'b0;
        bus.password_byte = 8'h00;
        bus.hash_in_byte = 8'hEE;
        bus.hash_in_valid = 1'b1;
        bus.hash_in_last = 1'b0;
        bus.pw_out_ready = 1'b1;
        repeat (3) tick();
        check_val("rst_store", 32'(bus.store_hash_byte), 0);
        check_val("rst_go", 32'(bus.go), 0);
        check_val("rst_ready", 32'(bus.hash_in_ready), 0);
        check_val("rst_pw_valid", 32'(bus.pw_out_valid), 0);
        check_val("rst_pw_last", 32'(bus.pw_out_last), 0);
        check_val("rst_new_hash", 32'(bus.new_hash_byte), 0);
        check_val("rst_pw_byte", 32'(bus.pw_out_byte), 0);
        check_val("rst_match_count", 32'(match_count), 0);
        check_val("rst_proto", 32'(proto_error), 0);
        do_reset();

        // Cracker never drops your_turn after a strobe.
        stuck = 1'b1;
        drive_byte(8'h55, 1'b0);
        serve_load(g);
        n = 0;
`ifdef NTCRACK_HOST_TIMEOUT_EN
        while (!bus.hash_in_ready && n < 200) begin tick(); n++; end
        check_val("timeout_cycles", 32'(n), 20);
        check_val("timeout_proto", 32'(proto_error), 1);
`else
        repeat (100) tick();
        check_val("stuck_not_idle", 32'(bus.hash_in_ready), 0);
        check_val("stuck_no_proto", 32'(proto_error), 0);
`endif
        stuck = 1'b0;
        do_reset();

        // Full 16-byte hash, then a 20-byte password with one stalled byte.
        go0 = n_go;
        st0 = n_store;
        for (int i = 0; i < 16; i++) begin
            drive_byte(8'(i), (i == 15));
            serve_load(g);
        end
        finish_load(g);
        check_val("load_store_count", 32'(n_store - st0), 16);
        check_val("load_go_count", 32'(n_go - go0), 1);
        check_val("load_q_empty", 32'(hash_q.size()), 0);
        check_val("load_proto", 32'(proto_error), 0);
        check_val("crack_no_valid", 32'(bus.pw_out_valid), 0);

        go0 = n_go;
        crack_pw(7);
        repeat (2) tick();
        check_val("pw_go_count", 32'(n_go - go0), 20);
        check_val("match_count_1", 32'(match_count), 1);
        check_val("pw_proto", 32'(proto_error), 0);
        bus.your_turn = 1'b1;
        tick();
        check_val("never_idle", 32'(bus.hash_in_ready), 0);

        // match_found without your_turn is an error and must not emit.
        bus.your_turn = 1'b0;
        bus.match_found = 1'b1;
        bus.password_byte = 8'hAB;
        tick();
        bus.match_found = 1'b0;
        tick();
        check_val("mf_no_turn_proto", 32'(proto_error), 1);
        check_val("mf_no_turn_valid", 32'(bus.pw_out_valid), 0);
        check_val("overlap_1", 32'(n_overlap), 0);
        do_reset();

        // Short hash: last on the 5th byte, 11 zero pads follow.
        go0 = n_go;
        st0 = n_store;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check_val("short_proto_before", 32'(proto_error), 0);
            drive_byte(8'hA0 + 8'(i), (i == 4));
            if (i == 4) for (int k = 0; k < 11; k++) hash_q.push_back(8'h00);
            serve_load(g);
        end
        check_val("short_proto_after", 32'(proto_error), 1);
        finish_load(g);
        check_val("short_store_count", 32'(n_store - st0), 16);
        check_val("short_go_count", 32'(n_go - go0), 1);
        check_val("short_q_empty", 32'(hash_q.size()), 0);
        check_val("overlap_2", 32'(n_overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ntcrack_host.md
NTCRACK_HOST -- requirements
Module: ntcrack_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, cycles allowed waiting on any your_turn edge before timeout.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: hash_in_byte  in  8  upstream hash byte; hash_in_valid  in  1; hash_in_last  in  1  final byte of final hash; hash_in_ready  out  1.
REQ-005 SHALL have ports: new_hash_byte  out  8; store_hash_byte  out  1; go  out  1  (to cracker).
REQ-006 SHALL have ports: your_turn  in  1; match_found  in  1; password_byte  in  8  (from cracker).
REQ-007 SHALL have ports: pw_out_byte  out  8; pw_out_valid  out  1; pw_out_last  out  1  byte 19 of a password; pw_out_ready  in  1.
REQ-008 SHALL have ports: match_count  out  8  passwords fully emitted; proto_error  out  1  sticky error.

Function
REQ-009 SHALL implement states IDLE, LOAD_STROBE, LOAD_WAIT_LOW, LOAD_WAIT_HIGH, GO_PULSE, GO_WAIT_LOW, CRACK, EMIT, ACK_PULSE, ACK_WAIT_LOW.
REQ-010 IDLE: hash_in_ready=1 only when your_turn=1; on hash_in_valid&hash_in_ready latch byte into new_hash_byte, latch last, go LOAD_STROBE.
REQ-011 LOAD_STROBE: store_hash_byte=1 exactly one cycle; next LOAD_WAIT_LOW.
REQ-012 new_hash_byte SHALL stay stable from strobe cycle until your_turn re-rises (cracker samples it one cycle after strobe).
REQ-013 LOAD_WAIT_LOW -> LOAD_WAIT_HIGH on your_turn=0; LOAD_WAIT_HIGH exits on your_turn=1: to GO_PULSE if latched last, else IDLE.
REQ-014 4-bit byte counter SHALL increment per stored byte, wrapping 15->0; hash_in_last with counter!=15 SHALL set proto_error and the block SHALL pad with 0x00 bytes (hash_in_ready=0) until counter wraps, then GO_PULSE.
REQ-015 GO_PULSE: go=1 one cycle; GO_WAIT_LOW waits your_turn=0, then CRACK.
REQ-016 CRACK: on match_found=1 & your_turn=1 capture password_byte into pw_out_byte, go EMIT.
REQ-017 EMIT: pw_out_valid=1 held until pw_out_ready=1; pw_out_last=1 when 5-bit password index==19; transfer cycle -> ACK_PULSE.
REQ-018 ACK_PULSE: go=1 one cycle; ACK_WAIT_LOW waits your_turn=0 then: index 19 -> index=0, match_count+1 (saturate 255), CRACK; else index+1, CRACK.
REQ-019 go and store_hash_byte SHALL never be high same cycle; each SHALL be a single-cycle pulse.
REQ-020 Block SHALL never return to IDLE after GO_PULSE except by reset; hash_in_ready=0 outside IDLE.
REQ-021 match_found=1 with your_turn=0, or match_found=1 in any load state, SHALL set proto_error and be ignored.

Reset
REQ-022 reset SHALL force IDLE, store_hash_byte=0, go=0, hash_in_ready=0 that cycle, pw_out_valid=0, pw_out_last=0, new_hash_byte=0, pw_out_byte=0, byte counter=0, password index=0, match_count=0, proto_error=0.
REQ-023 reset mid-operation SHALL NOT resynchronise the cracker; system reset SHALL restart both blocks together.

Configuration
REQ-024 With NTCRACK_HOST_TIMEOUT_EN defined, a counter SHALL run in every *_WAIT_* state; reaching TIMEOUT_CYCLES sets proto_error and forces IDLE.
REQ-025 Without NTCRACK_HOST_TIMEOUT_EN, no timeout counter SHALL exist and wait states SHALL wait indefinitely.

Verification
REQ-026 16 bytes 0x00..0x0F, last on 0x0F, cracker model -> 16 store_hash_byte pulses, bytes in order, then one go pulse, state CRACK.
REQ-027 Model reports 20-byte match "password" padded 0x20 -> pw_out bytes 0x70,0x61,...,0x20, pw_out_last on byte 20 only, 20 go pulses, match_count=1.
REQ-028 pw_out_ready held 0 for 50 cycles during EMIT -> pw_out_valid and pw_out_byte stable, no go pulse until transfer.
REQ-029 hash_in_last on 5th byte -> proto_error=1, 11 pad bytes 0x00 stored, then go.
REQ-030 NTCRACK_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=20, your_turn stuck 1 after strobe -> proto_error=1 and IDLE after 20 cycles; without macro, remains in LOAD_WAIT_LOW.
